// File: rtl/lif_router_pkg.sv
// Shared types and widths for the candidate scheduler / event router slice.
// Also holds the lane-slicing helpers for the flattened per-lane request buses.
package lif_router_pkg;

   localparam int NUM_REQ     = 4;
   localparam int REQ_IDX_W   = 2;
   localparam int NEURON_ID_W = 4;
   localparam int SCORE_W     = 4;
   localparam int CNT_W       = 8;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CLEAR   = 3'd1,
      ST_COLLECT = 3'd2,
      ST_FLUSH   = 3'd3,
      ST_DONE    = 3'd4
   } sched_state_t;

   function automatic logic [NEURON_ID_W-1:0] lane_neuron(
      input logic [NUM_REQ*NEURON_ID_W-1:0] lanes,
      input logic [REQ_IDX_W-1:0]           idx);
      return lanes[int'(idx)*NEURON_ID_W +: NEURON_ID_W];
   endfunction

   function automatic logic [SCORE_W-1:0] lane_score(
      input logic [NUM_REQ*SCORE_W-1:0] lanes,
      input logic [REQ_IDX_W-1:0]       idx);
      return lanes[int'(idx)*SCORE_W +: SCORE_W];
   endfunction

endpackage

// File: rtl/cand_scheduler_if.sv
// Lane request handshake plus the serialized candidate stream and step status.
interface cand_scheduler_if #(
   parameter int NUM_REQ = lif_router_pkg::NUM_REQ,
   parameter int CNT_W   = lif_router_pkg::CNT_W
);
   import lif_router_pkg::*;

   logic                             step_start;
   logic [NUM_REQ-1:0]               req_valid;
   logic [NUM_REQ-1:0]               req_ready;
   logic [NUM_REQ*NEURON_ID_W-1:0]   req_neuron;
   logic [NUM_REQ*SCORE_W-1:0]       req_score;
   logic [NUM_REQ-1:0]               req_done;
   logic                             scan_start_en;
   logic                             cand_valid;
   logic [NEURON_ID_W-1:0]           cand_neuron;
   logic [SCORE_W-1:0]               cand_score;
   logic                             busy;
   logic                             step_done;
   logic [CNT_W-1:0]                 cand_count;

   modport master (
      output step_start, req_valid, req_neuron, req_score, req_done,
      input  req_ready, scan_start_en, cand_valid, cand_neuron, cand_score,
             busy, step_done, cand_count
   );

   modport slave (
      input  step_start, req_valid, req_neuron, req_score, req_done,
      output req_ready, scan_start_en, cand_valid, cand_neuron, cand_score,
             busy, step_done, cand_count
   );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or above ptr, wrapping.
// Zero latency; produces no grant while en is low.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   input  logic               en,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   idx
);

   logic found;
   int   j;

   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      j     = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         j = (int'(ptr) + k) % NUM_REQ;
         if (en && !found && req[j]) begin
            grant[j] = 1'b1;
            idx      = IDX_W'(j);
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/cand_scheduler.sv
// Per-step sequencer: clear pulse, round-robin collect of lane candidates into a
// one-per-cycle registered stream (grant -> cand_valid in 1 cycle), flush, done pulse.
module cand_scheduler
   import lif_router_pkg::*;
#(
   parameter int NUM_REQ   = lif_router_pkg::NUM_REQ,
   parameter int REQ_IDX_W = lif_router_pkg::REQ_IDX_W,
   parameter int CNT_W     = lif_router_pkg::CNT_W
) (
   input logic              clk,
   input logic              rst_n,
   cand_scheduler_if.slave  bus
);

   sched_state_t           state;
   logic [REQ_IDX_W-1:0]   ptr;
   logic [REQ_IDX_W-1:0]   gnt_idx;
   logic [REQ_IDX_W-1:0]   ptr_nxt;
   logic [NUM_REQ-1:0]     gnt;
   logic                   arb_en;
   logic                   xfer;
   logic                   lanes_drained;
   logic                   scan_start_en_q;
   logic                   cand_valid_q;
   logic [NEURON_ID_W-1:0] cand_neuron_q;
   logic [SCORE_W-1:0]     cand_score_q;
   logic                   step_done_q;
   logic [CNT_W-1:0]       cnt;

   assign arb_en = (state == ST_COLLECT);

   rr_arbiter #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (REQ_IDX_W)
   ) u_arb (
      .req   (bus.req_valid),
      .ptr   (ptr),
      .en    (arb_en),
      .grant (gnt),
      .idx   (gnt_idx)
   );

   // Grant is a pure function of state/valid/ptr, so it is safe to expose directly.
   assign bus.req_ready  = gnt;
   assign xfer           = |gnt;
   assign lanes_drained  = (&bus.req_done) && !(|bus.req_valid);
   assign ptr_nxt        = (gnt_idx == REQ_IDX_W'(NUM_REQ - 1)) ? '0
                                                                 : gnt_idx + REQ_IDX_W'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= ST_IDLE;
         ptr             <= '0;
         cnt             <= '0;
         scan_start_en_q <= 1'b0;
         cand_valid_q    <= 1'b0;
         cand_neuron_q   <= '0;
         cand_score_q    <= '0;
         step_done_q     <= 1'b0;
      end else begin
         scan_start_en_q <= 1'b0;
         cand_valid_q    <= 1'b0;
         step_done_q     <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (bus.step_start) begin
                  state           <= ST_CLEAR;
                  scan_start_en_q <= 1'b1;
               end
            end
            ST_CLEAR: begin
               state <= ST_COLLECT;
               cnt   <= '0;
               ptr   <= '0;
            end
            ST_COLLECT: begin
               if (xfer) begin
                  cand_valid_q  <= 1'b1;
                  cand_neuron_q <= lane_neuron(bus.req_neuron, gnt_idx);
                  cand_score_q  <= lane_score(bus.req_score, gnt_idx);
                  ptr           <= ptr_nxt;
                  if (cnt != '1) cnt <= cnt + CNT_W'(1);
               end
               // Exit only once nothing is pending, so a lane with valid+done is still served.
               if (lanes_drained) state <= ST_FLUSH;
            end
            ST_FLUSH: begin
               state       <= ST_DONE;
               step_done_q <= 1'b1;
            end
            ST_DONE: begin
               state <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign bus.scan_start_en = scan_start_en_q;
   assign bus.cand_valid    = cand_valid_q;
   assign bus.cand_neuron   = cand_neuron_q;
   assign bus.cand_score    = cand_score_q;
   assign bus.step_done     = step_done_q;
   assign bus.cand_count    = cnt;
   assign bus.busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_cand_scheduler.sv
// Directed bench for cand_scheduler: drive at posedge+1, sample at posedge+2.
module tb_cand_scheduler;
   import lif_router_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   n_chk  = 0;
   int   n_pass = 0;
   int   scan_seen = 0;
   int   done_seen = 0;

   cand_scheduler_if bus ();

   cand_scheduler dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus.scan_start_en === 1'b1) scan_seen++;
      if (bus.step_done === 1'b1) done_seen++;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // step_start at t; lane 2 offers neuron 5 / score 9; all lanes done.
   task automatic single_cand(input string tag);
      int s0, d0;
      s0 = scan_seen;
      d0 = done_seen;
      bus.step_start = 1'b1;
      bus.req_valid  = 4'b0100;
      bus.req_done   = 4'hF;
      bus.req_neuron = 16'h0500;
      bus.req_score  = 16'h0900;
      #1 chk({tag, "_t0_rdy"}, bus.req_ready, 0);
      chk({tag, "_t0_busy"}, bus.busy, 0);
      tick(); bus.step_start = 1'b0;
      #1 chk({tag, "_t1_scan"}, bus.scan_start_en, 1);
      chk({tag, "_t1_rdy"}, bus.req_ready, 0);
      tick();
      #1 chk({tag, "_t2_rdy"}, bus.req_ready, 4'b0100);
      chk({tag, "_t2_scan"}, bus.scan_start_en, 0);
      tick(); bus.req_valid = 4'b0000;
      #1 chk({tag, "_t3_cv"}, bus.cand_valid, 1);
      chk({tag, "_t3_nrn"}, bus.cand_neuron, 5);
      chk({tag, "_t3_scr"}, bus.cand_score, 9);
      tick();
      #1 chk({tag, "_t4_cv"}, bus.cand_valid, 0);
      chk({tag, "_t4_done"}, bus.step_done, 0);
      chk({tag, "_t4_busy"}, bus.busy, 1);
      tick();
      #1 chk({tag, "_t5_done"}, bus.step_done, 1);
      chk({tag, "_t5_cnt"}, bus.cand_count, 1);
      tick();
      #1 chk({tag, "_t6_done"}, bus.step_done, 0);
      chk({tag, "_t6_busy"}, bus.busy, 0);
      chk({tag, "_scans"}, scan_seen - s0, 1);
      chk({tag, "_dones"}, done_seen - d0, 1);
   endtask

   initial begin
      int rem[4];
      int s0, d0;

      bus.step_start = 1'b0;
      bus.req_valid  = 4'hF;
      bus.req_done   = 4'h0;
      bus.req_neuron = '0;
      bus.req_score  = '0;

      // Reset and idle
      repeat (3) @(posedge clk);
      #1 chk("rst_rdy", bus.req_ready, 0);
      chk("rst_cv", bus.cand_valid, 0);
      chk("rst_scan", bus.scan_start_en, 0);
      chk("rst_busy", bus.busy, 0);
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         #1 chk("idle_rdy", bus.req_ready, 0);
         chk("idle_busy", bus.busy, 0);
         chk("idle_cv", bus.cand_valid, 0);
         chk("idle_scan", bus.scan_start_en, 0);
      end
      chk("idle_nrn", bus.cand_neuron, 0);
      chk("idle_scr", bus.cand_score, 0);
      chk("idle_done", bus.step_done, 0);
      chk("idle_cnt", bus.cand_count, 0);

      tick(); bus.req_valid = 4'h0;
      tick();
      single_cand("single");

      // Round-robin: every lane has 3 candidates, lane i neuron=i, score=8+i
      for (int i = 0; i < 4; i++) rem[i] = 3;
      tick();
      bus.req_neuron = {4'd3, 4'd2, 4'd1, 4'd0};
      bus.req_score  = {4'd11, 4'd10, 4'd9, 4'd8};
      bus.req_valid  = 4'hF;
      bus.req_done   = 4'h0;
      bus.step_start = 1'b1;
      tick(); bus.step_start = 1'b0;
      tick();
      for (int k = 0; k < 12; k++) begin
         for (int i = 0; i < 4; i++) begin
            bus.req_valid[i] = (rem[i] > 0);
            bus.req_done[i]  = (rem[i] == 0);
         end
         #1 chk("rr_gnt", bus.req_ready, 1 << (k % 4));
         if (k > 0) begin
            chk("rr_cv", bus.cand_valid, 1);
            chk("rr_nrn", bus.cand_neuron, (k - 1) % 4);
         end
         rem[k % 4]--;
         tick();
      end
      bus.req_valid = 4'h0;
      bus.req_done  = 4'hF;
      #1 chk("rr_last_cv", bus.cand_valid, 1);
      chk("rr_last_nrn", bus.cand_neuron, 3);
      chk("rr_last_scr", bus.cand_score, 11);
      chk("rr_last_rdy", bus.req_ready, 0);
      tick();
      #1 chk("rr_flush_cv", bus.cand_valid, 0);
      tick();
      #1 chk("rr_done", bus.step_done, 1);
      chk("rr_cnt", bus.cand_count, 12);

      // Pointer wrap/skip, with a stray step_start mid-COLLECT
      tick();
      s0 = scan_seen;
      d0 = done_seen;
      bus.req_neuron = {4'hD, 4'hC, 4'hB, 4'hA};
      bus.req_score  = {4'd3, 4'd2, 4'd1, 4'd0};
      bus.req_valid  = 4'h0;
      bus.req_done   = 4'h0;
      bus.step_start = 1'b1;
      tick(); bus.step_start = 1'b0;
      tick(); bus.req_valid = 4'b0100;
      #1 chk("wrap_g2", bus.req_ready, 4'b0100);
      tick(); bus.req_valid = 4'b1010; bus.step_start = 1'b1;
      #1 chk("wrap_g3", bus.req_ready, 4'b1000);
      chk("wrap_nrn_c", bus.cand_neuron, 4'hC);
      tick(); bus.req_valid = 4'b0010; bus.step_start = 1'b0;
      #1 chk("wrap_g1", bus.req_ready, 4'b0010);
      chk("wrap_nrn_d", bus.cand_neuron, 4'hD);
      chk("busy_scan", bus.scan_start_en, 0);
      tick(); bus.req_valid = 4'hF;
      #1 chk("wrap_ptr2", bus.req_ready, 4'b0100);
      chk("wrap_nrn_b", bus.cand_neuron, 4'hB);
      tick(); bus.req_valid = 4'h0; bus.req_done = 4'hF;
      #1 chk("wrap_nrn_c2", bus.cand_neuron, 4'hC);
      chk("wrap_rdy0", bus.req_ready, 0);
      tick();
      tick();
      #1 chk("wrap_done", bus.step_done, 1);
      chk("wrap_cnt", bus.cand_count, 4);
      tick(); tick();
      chk("busy_scans", scan_seen - s0, 1);
      chk("busy_dones", done_seen - d0, 1);

      // Empty step: all done, nothing valid
      bus.step_start = 1'b1;
      tick(); bus.step_start = 1'b0;
      #1 chk("empty_scan", bus.scan_start_en, 1);
      tick();
      #1 chk("empty_busy", bus.busy, 1);
      chk("empty_rdy", bus.req_ready, 0);
      tick();
      #1 chk("empty_flush", bus.step_done, 0);
      tick();
      #1 chk("empty_done", bus.step_done, 1);
      chk("empty_cnt", bus.cand_count, 0);

      // Single lane streaming for 260 cycles; count saturates at 255
      tick();
      bus.req_neuron = 16'h0007;
      bus.req_valid  = 4'b0001;
      bus.req_done   = 4'h0;
      bus.step_start = 1'b1;
      tick(); bus.step_start = 1'b0;
      tick();
      for (int k = 0; k < 260; k++) begin
         #1 chk("stream_gnt", bus.req_ready, 4'b0001);
         tick();
      end
      bus.req_valid = 4'h0;
      bus.req_done  = 4'hF;
      #1 chk("stream_cv", bus.cand_valid, 1);
      tick();
      tick();
      #1 chk("sat_done", bus.step_done, 1);
      chk("sat_cnt", bus.cand_count, 255);

      // Async reset mid-COLLECT while cand_valid is high
      tick();
      bus.req_valid  = 4'b0001;
      bus.req_done   = 4'h0;
      bus.step_start = 1'b1;
      tick(); bus.step_start = 1'b0;
      tick();
      tick();
      #1 chk("arst_pre_cv", bus.cand_valid, 1);
      d0 = done_seen;
      #2 rst_n = 1'b0;
      #1 chk("arst_cv", bus.cand_valid, 0);
      chk("arst_rdy", bus.req_ready, 0);
      chk("arst_busy", bus.busy, 0);
      tick(); tick();
      chk("arst_nodone", done_seen - d0, 0);
      rst_n = 1'b1;
      bus.req_valid = 4'h0;
      tick();
      single_cand("post_rst");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
